blob_feeder: RTL and testbench

BLOB_FEEDER -- requirements
Module: blob_feeder

---
 rtl/blob_feeder.sv | 137 +++++++++++++
 tb/tb_blob_feeder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_feeder.sv
// rtl/blob_feeder.sv - streams a frame from the frame store as binarized bits to a blob counter and collects the result
module blob_feeder #(
  parameter int IMG_COL = 640,
  parameter int IMG_ROW = 480,
  parameter int RD_LAT  = 2,
  parameter int TIMEOUT = 4096
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_threshold,
  output logic        o_busy,
  output logic        o_rd_en,
  output logic [18:0] o_rd_addr,
  input  logic [7:0]  i_rd_data,
  output logic        o_blob_valid,
  output logic        o_blob_seq,
  input  logic        i_blob_done,
  input  logic [7:0]  i_blob_count,
  output logic        o_done,
  output logic [7:0]  o_count,
  output logic [18:0] o_ones,
  output logic        o_timeout
);

  localparam int NPIX = IMG_COL * IMG_ROW;
  localparam int WW   = $clog2(TIMEOUT + 1);
  localparam logic [18:0]   LAST_ADDR = 19'(NPIX - 1);
  localparam logic [18:0]   END_ADDR  = 19'(NPIX);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT, S_DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [7:0]         thr;
  logic [18:0]        addr;
  logic [RD_LAT-1:0]  v_pipe;   // read data valid, aligned with i_rd_data at the tail
  logic [RD_LAT-1:0]  f_pipe;   // first pixel marker
  logic [RD_LAT-1:0]  l_pipe;   // last pixel marker
  logic               seq;
  logic               seq_last;
  logic               fg;
  logic               rd_en;
  logic               start_ok;
  logic [WW-1:0]      wcnt;
  logic [7:0]         count;
  logic [18:0]        ones;
  logic               timeout;

  assign start_ok = (state == S_IDLE) && i_start;
  assign rd_en    = (state == S_STREAM) && (addr != END_ADDR);
  assign fg       = v_pipe[RD_LAT-1] && (i_rd_data >= thr);

  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign o_rd_en      = rd_en;
  assign o_rd_addr    = addr;
  // blob_valid rides one cycle ahead of the registered pixel 0 bit
  assign o_blob_valid = f_pipe[RD_LAT-1];
  assign o_blob_seq   = seq;
  assign o_count      = count;
  assign o_ones       = ones;
  assign o_timeout    = timeout;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state decode; seq_last marks the cycle the final bit is on o_blob_seq
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (i_start) state_nxt = S_STREAM;
      S_STREAM: if (seq_last) state_nxt = S_WAIT;
      S_WAIT:   if (i_blob_done || (wcnt == WAIT_LAST)) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // address counter, read pipeline, binarizer, counters and result latches
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      thr      <= '0;
      addr     <= '0;
      v_pipe   <= '0;
      f_pipe   <= '0;
      l_pipe   <= '0;
      seq      <= 1'b0;
      seq_last <= 1'b0;
      wcnt     <= '0;
      count    <= '0;
      ones     <= '0;
      timeout  <= 1'b0;
    end else begin
      v_pipe[0] <= rd_en;
      f_pipe[0] <= rd_en && (addr == '0);
      l_pipe[0] <= rd_en && (addr == LAST_ADDR);
      for (int i = 1; i < RD_LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        f_pipe[i] <= f_pipe[i-1];
        l_pipe[i] <= l_pipe[i-1];
      end
      seq      <= fg;
      seq_last <= l_pipe[RD_LAT-1];
      if (fg) ones <= ones + 19'd1;

      if (start_ok) begin
        thr     <= i_threshold;
        addr    <= '0;
        ones    <= '0;
        count   <= '0;
        timeout <= 1'b0;
      end else if (rd_en) begin
        addr <= addr + 19'd1;
      end

      if (state == S_WAIT) wcnt <= wcnt + 1'b1;
      else                 wcnt <= '0;

      // a result strobe beats a coincident timeout
      if (state == S_WAIT) begin
        if (i_blob_done) begin
          count   <= i_blob_count;
          timeout <= 1'b0;
        end else if (wcnt == WAIT_LAST) begin
          count   <= '0;
          timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_blob_feeder.sv
// tb/tb_blob_feeder.sv - scoreboard bench for blob_feeder with RD_LAT 1 and 4 instances side by side
module tb_blob_feeder;

  localparam int COL  = 20;
  localparam int ROW  = 16;
  localparam int NPIX = COL * ROW;
  localparam int TMO  = 40;

  typedef struct packed {
    int   t;
    logic b;
  } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        blob_done = 1'b0;
  logic [7:0]  threshold = 8'h00;
  logic [7:0]  blob_count = 8'h00;

  logic        busy [2];
  logic        rd_en [2];
  logic [18:0] rd_addr [2];
  logic        blob_valid [2];
  logic        seq [2];
  logic        done [2];
  logic [7:0]  count [2];
  logic [18:0] ones [2];
  logic        timeout [2];

  int mode = 0;

  function automatic logic [7:0] pix(input int a);
    logic [7:0] r;
    case (mode)
      0:       r = 8'hFF;
      1:       r = 8'h00;
      default: r = a[7:0];
    endcase
    return r;
  endfunction

  function automatic int lat(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 4;
    logic [7:0] dpipe [LAT];
    logic [7:0] rdd;

    blob_feeder #(.IMG_COL(COL), .IMG_ROW(ROW), .RD_LAT(LAT), .TIMEOUT(TMO)) u_dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_threshold(threshold),
      .o_busy(busy[g]), .o_rd_en(rd_en[g]), .o_rd_addr(rd_addr[g]), .i_rd_data(rdd),
      .o_blob_valid(blob_valid[g]), .o_blob_seq(seq[g]),
      .i_blob_done(blob_done), .i_blob_count(blob_count),
      .o_done(done[g]), .o_count(count[g]), .o_ones(ones[g]), .o_timeout(timeout[g])
    );

    // frame-store model with LAT cycles of read latency
    always @(posedge clk) begin
      dpipe[0] <= rd_en[g] ? pix(int'(rd_addr[g])) : 8'h5A;
      for (int k = 1; k < LAT; k++) dpipe[k] <= dpipe[k-1];
    end
    assign rdd = dpipe[LAT-1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;

  ent_t sbq [2][$];
  int   vq  [2][$];
  int   nxt_addr [2] = '{NPIX, NPIX};
  int   last_rd [2];
  int   exp_ones [2];
  int   last_t [2];
  int   done_cyc [2];
  int   exp_done [2];
  logic [7:0] thr_lat = 8'h00;
  logic [7:0] exp_cnt = 8'h00;
  logic       exp_to = 1'b0;
  int   start_cyc = 0;

  task automatic step();
    ent_t e;
    logic bb;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (sbq[i].size() > 0 && sbq[i][0].t == cyc) begin
        e = sbq[i].pop_front();
        n_cmp++;
        if (seq[i] !== e.b) begin
          n_err++;
          $display("FAIL seq inst%0d cyc %0d: got %b want %b", i, cyc, seq[i], e.b);
        end
      end else if (seq[i] !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL seq_idle inst%0d cyc %0d: got %b want 0", i, cyc, seq[i]);
      end

      if (vq[i].size() > 0 && vq[i][0] == cyc) begin
        void'(vq[i].pop_front());
        n_cmp++;
        if (blob_valid[i] !== 1'b1) begin
          n_err++;
          $display("FAIL blob_valid inst%0d cyc %0d: got %b want 1", i, cyc, blob_valid[i]);
        end
      end else if (blob_valid[i] !== 1'b0) begin
        n_cmp++; n_err++;
        $display("FAIL blob_valid_idle inst%0d cyc %0d: got %b want 0", i, cyc, blob_valid[i]);
      end

      if (rd_en[i] === 1'b1) begin
        n_cmp++;
        if (nxt_addr[i] >= NPIX || rd_addr[i] !== 19'(nxt_addr[i])) begin
          n_err++;
          $display("FAIL rd_addr inst%0d cyc %0d: got %0d want %0d", i, cyc, rd_addr[i], nxt_addr[i]);
        end else if ((nxt_addr[i] == 0) ? (cyc != start_cyc + 1) : (cyc != last_rd[i] + 1)) begin
          n_err++;
          $display("FAIL rd_timing inst%0d addr %0d: got cyc %0d", i, nxt_addr[i], cyc);
        end
        if (nxt_addr[i] < NPIX) begin
          bb = (pix(nxt_addr[i]) >= thr_lat);
          e.t = cyc + lat(i) + 1;
          e.b = bb;
          sbq[i].push_back(e);
          if (nxt_addr[i] == 0) vq[i].push_back(cyc + lat(i));
          if (nxt_addr[i] == NPIX - 1) last_t[i] = cyc + lat(i) + 1;
          exp_ones[i] += int'(bb);
          nxt_addr[i]++;
        end
        last_rd[i] = cyc;
      end

      if (done[i] === 1'b1) begin
        done_cyc[i] = cyc;
        n_cmp++;
        if (count[i] !== exp_cnt || timeout[i] !== exp_to || ones[i] !== 19'(exp_ones[i]) ||
            (exp_done[i] >= 0 && cyc != exp_done[i])) begin
          n_err++;
          $display("FAIL result inst%0d: got cnt %0d to %b ones %0d cyc %0d want cnt %0d to %b ones %0d cyc %0d",
                   i, count[i], timeout[i], ones[i], cyc, exp_cnt, exp_to, exp_ones[i], exp_done[i]);
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({busy[i], rd_en[i], rd_addr[i], blob_valid[i], seq[i], done[i], count[i], ones[i], timeout[i]} !== '0) begin
        n_err++;
        $display("FAIL %s inst%0d: got busy %b rd_en %b addr %0d bv %b seq %b done %b cnt %0d ones %0d to %b want all 0",
                 tag, i, busy[i], rd_en[i], rd_addr[i], blob_valid[i], seq[i], done[i], count[i], ones[i], timeout[i]);
      end
    end
  endtask

  // dmode 0: result after both in WAIT, 1: no result, 2: result coincident with inst0 timeout
  task automatic run_frame(input logic [7:0] thr, input int dmode, input logic [7:0] cnt,
                           input bit disturb, input int rst_at);
    int e0, e1;
    bit finished;
    for (int i = 0; i < 2; i++) begin
      nxt_addr[i] = 0; exp_ones[i] = 0; last_t[i] = -1; done_cyc[i] = -1; exp_done[i] = -1;
      sbq[i].delete(); vq[i].delete();
    end
    exp_cnt = 8'h00; exp_to = 1'b0;
    threshold = thr; thr_lat = thr; start = 1'b1; start_cyc = cyc;
    finished = 1'b0;
    for (int n = 0; n < NPIX + TMO + 60; n++) begin
      step();
      start = 1'b0; blob_done = 1'b0;
      if (rst_at >= 0 && rd_en[0] === 1'b1 && rd_addr[0] == 19'(rst_at)) begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
          sbq[i].delete(); vq[i].delete(); nxt_addr[i] = NPIX;
        end
        step();
        check_reset_outputs("reset_mid");
        rst = 1'b0;
        return;
      end
      if (disturb && done[1] === 1'b1) start = 1'b1;
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) begin
        finished = 1'b1;
        break;
      end
      if (last_t[0] >= 0 && last_t[1] >= 0) begin
        e0 = last_t[0] + 1;
        e1 = last_t[1] + 1;
        if ((dmode == 0 && cyc == e1 + 2) || (dmode == 2 && cyc == e0 + TMO - 1)) begin
          blob_done = 1'b1; blob_count = cnt;
          exp_cnt = cnt; exp_to = 1'b0;
          exp_done[0] = cyc + 1; exp_done[1] = cyc + 1;
        end
        if (dmode == 1) begin
          exp_cnt = 8'h00; exp_to = 1'b1;
          exp_done[0] = e0 + TMO; exp_done[1] = e1 + TMO;
        end
        if (disturb && cyc == e0 + 1) start = 1'b1;
      end
      if (disturb && cyc == start_cyc + 50) begin
        start = 1'b1; blob_done = 1'b1; blob_count = 8'hEE; threshold = ~thr;
      end
    end
    n_cmp++;
    if (!finished) begin
      n_err++;
      $display("FAIL done_budget: got done cyc %0d/%0d want both seen", done_cyc[0], done_cyc[1]);
    end
    step();
    start = 1'b0; blob_done = 1'b0;
    for (int k = 0; k < 4; k++) step();
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (busy[i] !== 1'b0 || done[i] !== 1'b0) begin
        n_err++;
        $display("FAIL idle_after inst%0d: got busy %b done %b want 0 0", i, busy[i], done[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; threshold = 8'h10;
    step(); step();
    check_reset_outputs("reset_state");
    rst = 1'b0; start = 1'b0;
    step();
    check_reset_outputs("reset_over_start");
  endtask

  task automatic test_all_high();
    mode = 0;
    run_frame(8'd128, 0, 8'd1, 1'b0, -1);
  endtask

  task automatic test_all_zero();
    mode = 1;
    run_frame(8'd1, 1, 8'd0, 1'b0, -1);
    run_frame(8'd0, 0, 8'd5, 1'b0, -1);
  endtask

  task automatic test_ramp();
    mode = 2;
    run_frame(8'd200, 2, 8'd7, 1'b0, -1);
  endtask

  task automatic test_timeout();
    mode = 2;
    run_frame(8'd200, 1, 8'd0, 1'b0, -1);
  endtask

  task automatic test_ignored_inputs();
    mode = 2;
    run_frame(8'd100, 0, 8'h42, 1'b1, -1);
  endtask

  task automatic test_reset_mid();
    mode = 2;
    run_frame(8'd200, 0, 8'h09, 1'b0, 100);
    run_frame(8'd200, 0, 8'h33, 1'b0, -1);
  endtask

  task automatic test_back_to_back();
    mode = 2;
    run_frame(8'd50, 0, 8'h11, 1'b0, -1);
    run_frame(8'd250, 0, 8'h22, 1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_all_high();
    test_all_zero();
    test_ramp();
    test_timeout();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
